// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard port: receiver FSM states,
// bus address, scan-code prefixes and the layout of the polled status word.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [31:0] PS2_ADDR  = 32'hA000_0000;
  localparam logic [7:0]  SC_EXT    = 8'hE0;
  localparam logic [7:0]  SC_BREAK  = 8'hF0;

  localparam int VALID_BIT = 31;
  localparam int OVF_BIT   = 30;

  // PS/2 uses odd parity over data+parity, and the stop bit must be high.
  function automatic logic frame_ok(input logic [7:0] data,
                                    input logic       parity,
                                    input logic       stop);
    return stop & (^{parity, data});
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM
// and parity check. Define PS2_TIMEOUT_EN to discard stalled partial frames.
module ps2_rx_frame
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ps2_rx_frame: TIMEOUT_CYCLES must be at least 2");
  end

  logic      r_clk_s1, r_clk_s2, r_clk_s3;
  logic      r_dat_s1, r_dat_s2;
  logic      w_fall;
  logic      w_timeout;
  rx_state_e r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_parity;

  // NOTE: synchronisers reset to 1 so an idle-high bus does not look like a falling edge after reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_s3 & ~r_clk_s2;

`ifdef PS2_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_IDLE || w_fall || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_to_cnt == CW'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_parity <= r_dat_s2;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            // Bad frames simply fall back to IDLE without a push.
            if (frame_ok(r_shift, r_parity, r_dat_s2)) begin
              o_byte       <= r_shift;
              o_byte_valid <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (w_timeout) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_port.sv
// Memory-mapped PS/2 keyboard port: received scan codes are queued in a FIFO and
// polled as one status/data word. PS2_TIMEOUT_EN enables the receiver timeout.
module ps2_kbd_port
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd,
  output logic [31:0] rdata,
  output logic        overflow
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ps2_kbd_port: FIFO_DEPTH must be a power of two in 2..64");
  end

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    w_byte;
  logic          w_byte_valid;
  logic          w_full, w_empty;
  logic          w_push, w_pop, w_drop;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .clrn        (clrn),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid)
  );

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_pop   = rd & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push  = w_byte_valid & (~w_full | w_pop);
  assign w_drop  = w_byte_valid & w_full & ~w_pop;

  // NOTE: storage is not reset; w_empty masks stale contents from rdata.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_byte;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (rd) begin
      r_overflow <= 1'b0;
    end
  end

  // NOTE: every output bit gets a default first so no latch is inferred.
  always_comb begin
    rdata            = '0;
    rdata[VALID_BIT] = ~w_empty;
    rdata[OVF_BIT]   = r_overflow;
    if (!w_empty) rdata[7:0] = r_mem[r_rd_ptr];
  end

  assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_kbd_port.sv
// Self-checking bench for ps2_kbd_port: directed frames plus random traffic,
// compared against a queue-based model of the scan-code FIFO.
`timescale 1ns/1ps
module tb_ps2_kbd_port;
  import ps2_kbd_pkg::*;

  localparam int DEPTH    = 8;
  localparam int TO_CYC   = 200;
  localparam int HALF_BIT = 10;

  logic        clk      = 1'b0;
  logic        clrn     = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd       = 1'b0;
  logic [31:0] rdata;
  logic        overflow;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;

  ps2_kbd_port #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk     (clk),
    .clrn    (clrn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rd      (rd),
    .rdata   (rdata),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time (passed %0d of %0d)",
             checks_passed, checks_total);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rdata();
    logic [31:0] w;
    w     = '0;
    w[31] = (model_q.size() != 0);
    w[30] = model_ovf;
    if (model_q.size() != 0) w[7:0] = model_q[0];
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_port(input string tag);
    check(tag, rdata, exp_rdata());
    check({tag, "/ovf"}, {31'b0, overflow}, {31'b0, model_ovf});
  endtask

  // Drives the first nbits of a frame; optionally strobes rd so that it lands
  // in the same clk cycle as the resulting FIFO push.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int nbits, input bit pop_at_push);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(HALF_BIT);
      ps2_clk = 1'b0;
      if (pop_at_push && i == 10) begin
        cyc(3);
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
        cyc(HALF_BIT - 4);
      end else begin
        cyc(HALF_BIT);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (nbits == 11) begin
      if (pop_at_push) begin
        if (model_q.size() != 0) void'(model_q.pop_front());
        model_ovf = 1'b0;
      end
      if (!bad_par) begin
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
      end
    end
    cyc(4);
  endtask

  task automatic do_pop(input string tag);
    rd = 1'b1;
    check_port({tag, "/pre"});
    cyc(1);
    rd = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
    model_ovf = 1'b0;
    check_port(tag);
  endtask

  initial begin
    logic [7:0] seq [5];
    logic [7:0] rb;

    // Reset state
    cyc(3);
    check_port("reset");
    clrn = 1'b1;
    cyc(2);
    check_port("after_reset");

    // Single frame, stable without rd, then one pop
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    check("single", rdata, 32'h8000_001C);
    cyc(20);
    check_port("single_stable");
    do_pop("single_pop");
    check("single_empty", rdata, 32'h0);

    // Make/break sequence passes through untranslated and in order
    seq = '{SC_EXT, 8'h75, SC_EXT, SC_BREAK, 8'h75};
    foreach (seq[i]) send_frame(seq[i], 1'b0, 11, 1'b0);
    foreach (seq[i]) begin
      check("seq_head", {24'b0, rdata[7:0]}, {24'b0, seq[i]});
      do_pop("seq_pop");
    end
    check("seq_empty", {31'b0, rdata[31]}, 32'h0);

    // Bad parity is dropped, following good frame accepted
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    check("bad_parity", rdata, 32'h0);
    send_frame(8'h29, 1'b0, 11, 1'b0);
    check("after_bad", rdata, 32'h8000_0029);
    do_pop("after_bad_pop");

    // Overflow: nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 11, 1'b0);
    check("ovf_word", rdata, 32'hC000_0001);
    check("ovf_flag", {31'b0, overflow}, 32'h1);
    do_pop("ovf_pop");
    check("ovf_cleared", rdata, 32'h8000_0002);

    // Refill to full, then a push that coincides with a pop
    send_frame(8'h0A, 1'b0, 11, 1'b0);
    check_port("refill_full");
    send_frame(8'h0B, 1'b0, 11, 1'b1);
    check("coincide_word", rdata, 32'h8000_0003);
    check("coincide_ovf", {31'b0, overflow}, 32'h0);
    for (int i = 0; i < DEPTH; i++) do_pop("coincide_drain");
    check("coincide_empty", rdata, 32'h0);

`ifdef PS2_TIMEOUT_EN
    // Truncated frame is discarded after the timeout
    send_frame(8'h5A, 1'b0, 5, 1'b0);
    cyc(TO_CYC + 10);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    check("timeout_word", rdata, 32'h8000_001C);
    do_pop("timeout_pop");
    check("timeout_empty", rdata, 32'h0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_pop("rand_pop");
      end else begin
        rb = 8'($urandom_range(0, 255));
        send_frame(rb, ($urandom_range(0, 3) == 0), 11, 1'b0);
        check_port("rand_frame");
      end
    end

    // Reset in the middle of a frame
    send_frame(8'h33, 1'b0, 11, 1'b0);
    send_frame(8'h44, 1'b0, 5, 1'b0);
    clrn = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    check("midreset_word", rdata, 32'h0);
    check("midreset_ovf", {31'b0, overflow}, 32'h0);
    cyc(2);
    clrn = 1'b1;
    cyc(2);
    send_frame(8'h29, 1'b0, 11, 1'b0);
    check("post_reset", rdata, 32'h8000_0029);
    do_pop("post_reset_pop");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
